dpll_phase_filter: RTL and testbench

Phase detector and random-walk filter for the all-digital PLL. It sits directly upstream of the frequency divider and phase controller. It compares the external reference against the divider's recovered output and averages the lead/lag decisions with an up/down counter. It then issues the one-cycle `Positive` (hold one count) and `Negative` (add two counts) correction pulses that the divider consumes synchronously on `MainClock`.

---
 rtl/dpll_pkg.sv | 25 ++
 rtl/edge_synchronizer.sv | 22 ++
 rtl/dpll_phase_filter.sv | 99 +++++++++
 tb/tb_dpll_phase_filter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared constants and types for the DPLL phase detector / random-walk filter.
package dpll_pkg;

  localparam int DefFilterK       = 8;
  localparam int DefCounterWidth  = 8;
  localparam int DefLockThreshold = 16;
  localparam int LockWidth        = 8;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LEAD = 2'd1,
    LAG  = 2'd2
  } phaseDecision_e;

  // Filter state after one lead/lag decision.
  typedef struct packed {
    logic pulsePos;
    logic pulseNeg;
  } correction_t;

  function automatic logic [LockWidth-1:0] satInc(input logic [LockWidth-1:0] val);
    return (&val) ? val : val + LockWidth'(1);
  endfunction

endpackage

// File: rtl/edge_synchronizer.sv
// Two-flop synchronizer plus history flop; Rise is a one-cycle pulse on a
// synchronized 0->1 transition of AsyncIn.
module edge_synchronizer (
  input  logic MainClock,
  input  logic ResetN,
  input  logic AsyncIn,
  output logic Level,
  output logic Rise
);

  // syncPipe[0]=s1, [1]=s2, [2]=s3 (history)
  logic [2:0] syncPipe;

  always_ff @(posedge MainClock) begin
    if (!ResetN) syncPipe <= '0;
    else         syncPipe <= {syncPipe[1:0], AsyncIn};
  end

  assign Level = syncPipe[1];
  assign Rise  = syncPipe[1] & ~syncPipe[2];

endmodule

// File: rtl/dpll_phase_filter.sv
// Phase detector, saturating random-walk filter and lock detector feeding the
// DPLL divider with one-cycle Positive/Negative correction pulses.
module dpll_phase_filter
  import dpll_pkg::*;
#(
  parameter int FilterK       = DefFilterK,
  parameter int CounterWidth  = DefCounterWidth,
  parameter int LockThreshold = DefLockThreshold
) (
  input  logic                           MainClock,
  input  logic                           ResetN,
  input  logic                           ReferenceIn,
  input  logic                           FeedbackIn,
  input  logic                           Enable,
  output logic                           Positive,
  output logic                           Negative,
  output logic signed [CounterWidth-1:0] FilterCount,
  output logic                           Locked
);

  localparam logic signed [CounterWidth-1:0] UpperLimit = CounterWidth'(FilterK - 1);
  localparam logic signed [CounterWidth-1:0] LowerLimit = -UpperLimit;
  localparam logic signed [CounterWidth-1:0] CountOne   = CounterWidth'(1);
  localparam logic [LockWidth-1:0]           LockLimit  = LockWidth'(LockThreshold);

  logic refRise;
  logic refLevel;

  edge_synchronizer refSync (
    .MainClock (MainClock),
    .ResetN    (ResetN),
    .AsyncIn   (ReferenceIn),
    .Level     (refLevel),
    .Rise      (refRise)
  );

  phaseDecision_e decision;

  always_comb begin
    decision = NONE;
    if (refRise) decision = FeedbackIn ? LEAD : LAG;
  end

  logic signed [CounterWidth-1:0] countNext;
  correction_t                    corrNext;
  logic [LockWidth-1:0]           lockCount;
  logic [LockWidth-1:0]           lockNext;

  // Reaching +/-FilterK is detected one step early so the counter never
  // leaves -(FilterK-1)..+(FilterK-1) and never needs a wider comparison.
  always_comb begin
    countNext = FilterCount;
    corrNext  = '0;
    lockNext  = lockCount;
    if (Enable) begin
      unique case (decision)
        LEAD: begin
          if (FilterCount == UpperLimit) begin
            countNext         = '0;
            corrNext.pulsePos = 1'b1;
          end else begin
            countNext = FilterCount + CountOne;
          end
        end
        LAG: begin
          if (FilterCount == LowerLimit) begin
            countNext         = '0;
            corrNext.pulseNeg = 1'b1;
          end else begin
            countNext = FilterCount - CountOne;
          end
        end
        default: ;
      endcase
      if (corrNext.pulsePos || corrNext.pulseNeg) lockNext = '0;
      else if (decision != NONE)                  lockNext = satInc(lockCount);
    end
  end

  always_ff @(posedge MainClock) begin
    if (!ResetN) begin
      FilterCount <= '0;
      lockCount   <= '0;
      Positive    <= 1'b0;
      Negative    <= 1'b0;
      Locked      <= 1'b0;
    end else begin
      FilterCount <= countNext;
      lockCount   <= lockNext;
      Positive    <= corrNext.pulsePos;
      Negative    <= corrNext.pulseNeg;
      Locked      <= (lockNext >= LockLimit);
    end
  end

  logic unusedLevel;
  assign unusedLevel = refLevel;

endmodule

// File: tb/tb_dpll_phase_filter.sv
// Directed bench for dpll_phase_filter with default parameters (K=8, lock=16).
module tb_dpll_phase_filter;

  logic              MainClock = 1'b0;
  logic              ResetN    = 1'b0;
  logic              ReferenceIn = 1'b0;
  logic              FeedbackIn  = 1'b0;
  logic              Enable      = 1'b1;
  logic              Positive;
  logic              Negative;
  logic signed [7:0] FilterCount;
  logic              Locked;

  int checks   = 0;
  int failures = 0;

  always #5 MainClock = ~MainClock;

  dpll_phase_filter dut (
    .MainClock   (MainClock),
    .ResetN      (ResetN),
    .ReferenceIn (ReferenceIn),
    .FeedbackIn  (FeedbackIn),
    .Enable      (Enable),
    .Positive    (Positive),
    .Negative    (Negative),
    .FilterCount (FilterCount),
    .Locked      (Locked)
  );

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One reference pulse: high from E0 through E2, low afterwards.
  task automatic doRise(input string tag, input logic fb, input logic en,
                        input logic expPos, input logic expNeg,
                        input int expCount, input logic expLocked);
    @(negedge MainClock);
    FeedbackIn  = fb;
    Enable      = en;
    ReferenceIn = 1'b1;
    repeat (3) @(posedge MainClock);
    #1;
    check({tag, " pos"},    32'(Positive), 32'(expPos));
    check({tag, " neg"},    32'(Negative), 32'(expNeg));
    check({tag, " count"},  32'(FilterCount), expCount);
    check({tag, " locked"}, 32'(Locked), 32'(expLocked));
    @(negedge MainClock);
    ReferenceIn = 1'b0;
    @(posedge MainClock);
    #1;
    check({tag, " pulse-end"}, 32'({Positive, Negative}), 0);
    repeat (2) @(posedge MainClock);
  endtask

  initial begin
    // Reset held 3 cycles with the reference toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge MainClock);
      ReferenceIn = ~ReferenceIn;
      @(posedge MainClock);
      #1;
      check($sformatf("reset%0d outs", i), 32'({Positive, Negative, Locked}), 0);
      check($sformatf("reset%0d count", i), 32'(FilterCount), 0);
    end
    @(negedge MainClock);
    ReferenceIn = 1'b0;
    ResetN      = 1'b1;
    repeat (4) @(posedge MainClock);
    #1;
    check("post-reset count", 32'(FilterCount), 0);

    // Lead accumulation: 1..7 then Positive on the 8th
    for (int i = 1; i <= 8; i++)
      doRise($sformatf("lead%0d", i), 1'b1, 1'b1, i == 8, 1'b0, (i == 8) ? 0 : i, 1'b0);

    // Lag accumulation: -1..-7 then Negative on the 8th
    for (int i = 1; i <= 8; i++)
      doRise($sformatf("lag%0d", i), 1'b0, 1'b1, 1'b0, i == 8, (i == 8) ? 0 : -i, 1'b0);

    // Random walk: alternating lead/lag, lock at the 16th rise
    for (int i = 1; i <= 40; i++)
      doRise($sformatf("walk%0d", i), i[0], 1'b1, 1'b0, 1'b0, i % 2, i >= 16);

    // Lock loss: eight leads while locked
    for (int i = 1; i <= 8; i++)
      doRise($sformatf("loss%0d", i), 1'b1, 1'b1, i == 8, 1'b0, (i == 8) ? 0 : i, i != 8);

    // Enable gating: reach +7, five disabled leads, then one enabled lead
    for (int i = 1; i <= 7; i++)
      doRise($sformatf("pre%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, i, 1'b0);
    for (int i = 1; i <= 5; i++)
      doRise($sformatf("dis%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 7, 1'b0);
    doRise("reen", 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Reset mid-stream at -5
    for (int i = 1; i <= 5; i++)
      doRise($sformatf("neg%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, -i, 1'b0);
    check("pre-reset count", 32'(FilterCount), -5);
    @(negedge MainClock);
    ResetN = 1'b0;
    @(posedge MainClock);
    #1;
    check("midreset count", 32'(FilterCount), 0);
    check("midreset locked", 32'(Locked), 0);
    @(negedge MainClock);
    ResetN = 1'b1;
    repeat (2) @(posedge MainClock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
